// File: rtl/cpu_control_package.sv
// Shared opcode, instruction-format and control-word definitions for the decode stage.
package cpu_control_package;

    localparam int unsigned INSTR_W = 32;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_BRANCH = 7'b1100011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111
    } opcode_type_t;

    typedef enum logic [2:0] {
        R_TYPE = 3'd0,
        I_TYPE = 3'd1,
        S_TYPE = 3'd2,
        B_TYPE = 3'd3,
        U_TYPE = 3'd4,
        J_TYPE = 3'd5
    } instruction_type_t;

    localparam logic [2:0] F3_LB   = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;
    localparam logic [2:0] F3_SB   = 3'b000;
    localparam logic [2:0] F3_SH   = 3'b001;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;
    localparam logic [1:0] RES_IMM = 2'd3;

    typedef struct packed {
        logic              reg_write;
        logic              alu_select;
        logic              dmem_write;
        logic              dmem_read;
        logic              branch;
        logic              jump;
        logic              muldiv;
        logic              illegal;
        logic [1:0]        result_select;
        logic [1:0]        mem_size;
        logic              mem_unsigned;
        instruction_type_t instruction_type;
    } ctrl_t;

endpackage

// File: rtl/control_decode_logic.sv
// Combinational instruction decoder: control word plus sign-extended immediate.
// Define CPU_DECODE_MEXT_EN to accept the multiply/divide (funct7 0000001) OP group.
module control_decode_logic
    import cpu_control_package::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INSTR_W-1:0] instr,
    output ctrl_t              ctrl_c,
    output logic [XLEN-1:0]    imm_c
);

    opcode_type_t       opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic               legal;
    ctrl_t              dec;
    logic signed [31:0] imm32;

    assign opcode = opcode_type_t'(instr[6:0]);
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        dec                  = '0;
        dec.instruction_type = R_TYPE;
        legal                = 1'b0;
        case (opcode)
            OPC_LOAD: begin
                if (funct3 == F3_LB || funct3 == F3_LH || funct3 == F3_LW ||
                    funct3 == F3_LBU || funct3 == F3_LHU) begin
                    legal                = 1'b1;
                    dec.reg_write        = 1'b1;
                    dec.alu_select       = 1'b1;
                    dec.dmem_read        = 1'b1;
                    dec.result_select    = RES_MEM;
                    dec.mem_size         = funct3[1:0];
                    dec.mem_unsigned     = funct3[2];
                    dec.instruction_type = I_TYPE;
                end
            end
            OPC_STORE: begin
                if (funct3 == F3_SB || funct3 == F3_SH || funct3 == F3_SW) begin
                    legal                = 1'b1;
                    dec.alu_select       = 1'b1;
                    dec.dmem_write       = 1'b1;
                    dec.mem_size         = funct3[1:0];
                    dec.instruction_type = S_TYPE;
                end
            end
            OPC_OP_IMM: begin
                legal                = 1'b1;
                dec.reg_write        = 1'b1;
                dec.alu_select       = 1'b1;
                dec.result_select    = RES_ALU;
                dec.instruction_type = I_TYPE;
            end
            OPC_OP: begin
                if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                    legal                = 1'b1;
                    dec.reg_write        = 1'b1;
                    dec.result_select    = RES_ALU;
                    dec.instruction_type = R_TYPE;
                end
`ifdef CPU_DECODE_MEXT_EN
                else if (funct7 == F7_MULDIV) begin
                    legal                = 1'b1;
                    dec.reg_write        = 1'b1;
                    dec.muldiv           = 1'b1;
                    dec.result_select    = RES_ALU;
                    dec.instruction_type = R_TYPE;
                end
`endif
            end
            OPC_BRANCH: begin
                if (funct3 == F3_BEQ || funct3 == F3_BNE || funct3 == F3_BLT ||
                    funct3 == F3_BGE || funct3 == F3_BLTU || funct3 == F3_BGEU) begin
                    legal                = 1'b1;
                    dec.branch           = 1'b1;
                    dec.instruction_type = B_TYPE;
                end
            end
            OPC_LUI: begin
                legal                = 1'b1;
                dec.reg_write        = 1'b1;
                dec.result_select    = RES_IMM;
                dec.instruction_type = U_TYPE;
            end
            OPC_AUIPC: begin
                legal                = 1'b1;
                dec.reg_write        = 1'b1;
                dec.alu_select       = 1'b1;
                dec.result_select    = RES_ALU;
                dec.instruction_type = U_TYPE;
            end
            OPC_JAL: begin
                legal                = 1'b1;
                dec.jump             = 1'b1;
                dec.reg_write        = 1'b1;
                dec.result_select    = RES_PC4;
                dec.instruction_type = J_TYPE;
            end
            OPC_JALR: begin
                if (funct3 == F3_JALR) begin
                    legal                = 1'b1;
                    dec.jump             = 1'b1;
                    dec.reg_write        = 1'b1;
                    dec.alu_select       = 1'b1;
                    dec.result_select    = RES_PC4;
                    dec.instruction_type = I_TYPE;
                end
            end
            default: ;
        endcase
        // Anything unrecognised collapses to a clean illegal word
        if (!legal) begin
            dec                  = '0;
            dec.instruction_type = R_TYPE;
            dec.illegal          = 1'b1;
        end
    end

    // Immediate is assembled at 32 bits and sign-extended to XLEN afterwards
    always_comb begin
        case (dec.instruction_type)
            I_TYPE:  imm32 = {{20{instr[31]}}, instr[31:20]};
            S_TYPE:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            B_TYPE:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            U_TYPE:  imm32 = {instr[31:12], 12'b0};
            J_TYPE:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign ctrl_c = dec;
    assign imm_c  = XLEN'(imm32);

endmodule

// File: rtl/control_decode_stage.sv
// Registered decode stage with a two-entry skid buffer between fetch and execute.
// Define CPU_DECODE_MEXT_EN to enable multiply/divide decode in control_decode_logic.
module control_decode_stage
    import cpu_control_package::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_W-1:0]     instr,
    input  logic [XLEN-1:0]        pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   flush,
    output logic                   reg_write,
    output logic                   alu_select,
    output logic                   dmem_write,
    output logic                   dmem_read,
    output logic                   branch,
    output logic                   jump,
    output logic                   muldiv,
    output logic                   illegal,
    output logic [1:0]             result_select,
    output logic [1:0]             mem_size,
    output logic                   mem_unsigned,
    output instruction_type_t      instruction_type,
    output logic [2:0]             funct3,
    output logic [4:0]             rd,
    output logic [4:0]             rs1,
    output logic [4:0]             rs2,
    output logic [XLEN-1:0]        imm,
    output logic [XLEN-1:0]        pc_out
);

    ctrl_t           dec_ctrl_c;
    logic [XLEN-1:0] dec_imm_c;
    logic            in_fire_c;

    logic            main_valid;
    ctrl_t           main_ctrl;
    logic [2:0]      main_funct3;
    logic [4:0]      main_rd;
    logic [4:0]      main_rs1;
    logic [4:0]      main_rs2;
    logic [XLEN-1:0] main_imm;
    logic [XLEN-1:0] main_pc;

    logic            skid_valid;
    ctrl_t           skid_ctrl;
    logic [2:0]      skid_funct3;
    logic [4:0]      skid_rd;
    logic [4:0]      skid_rs1;
    logic [4:0]      skid_rs2;
    logic [XLEN-1:0] skid_imm;
    logic [XLEN-1:0] skid_pc;

    control_decode_logic #(
        .XLEN   (XLEN)
    ) u_decode (
        .instr  (instr),
        .ctrl_c (dec_ctrl_c),
        .imm_c  (dec_imm_c)
    );

    assign in_fire_c = in_valid && in_ready;

    // Main feeds execute; skid catches the one instruction accepted during a stall
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid  <= 1'b0;
            main_ctrl   <= '0;
            main_funct3 <= '0;
            main_rd     <= '0;
            main_rs1    <= '0;
            main_rs2    <= '0;
            main_imm    <= '0;
            main_pc     <= '0;
            skid_valid  <= 1'b0;
            skid_ctrl   <= '0;
            skid_funct3 <= '0;
            skid_rd     <= '0;
            skid_rs1    <= '0;
            skid_rs2    <= '0;
            skid_imm    <= '0;
            skid_pc     <= '0;
            in_ready    <= 1'b1;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (!main_valid || out_ready) begin
            if (skid_valid) begin
                main_valid  <= 1'b1;
                main_ctrl   <= skid_ctrl;
                main_funct3 <= skid_funct3;
                main_rd     <= skid_rd;
                main_rs1    <= skid_rs1;
                main_rs2    <= skid_rs2;
                main_imm    <= skid_imm;
                main_pc     <= skid_pc;
                skid_valid  <= 1'b0;
                in_ready    <= 1'b1;
            end else if (in_fire_c) begin
                main_valid  <= 1'b1;
                main_ctrl   <= dec_ctrl_c;
                main_funct3 <= instr[14:12];
                main_rd     <= instr[11:7];
                main_rs1    <= instr[19:15];
                main_rs2    <= instr[24:20];
                main_imm    <= dec_imm_c;
                main_pc     <= pc;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_fire_c) begin
            skid_valid  <= 1'b1;
            skid_ctrl   <= dec_ctrl_c;
            skid_funct3 <= instr[14:12];
            skid_rd     <= instr[11:7];
            skid_rs1    <= instr[19:15];
            skid_rs2    <= instr[24:20];
            skid_imm    <= dec_imm_c;
            skid_pc     <= pc;
            in_ready    <= 1'b0;
        end
    end

    assign out_valid        = main_valid;
    assign reg_write        = main_ctrl.reg_write;
    assign alu_select       = main_ctrl.alu_select;
    assign dmem_write       = main_ctrl.dmem_write;
    assign dmem_read        = main_ctrl.dmem_read;
    assign branch           = main_ctrl.branch;
    assign jump             = main_ctrl.jump;
    assign muldiv           = main_ctrl.muldiv;
    assign illegal          = main_ctrl.illegal;
    assign result_select    = main_ctrl.result_select;
    assign mem_size         = main_ctrl.mem_size;
    assign mem_unsigned     = main_ctrl.mem_unsigned;
    assign instruction_type = main_ctrl.instruction_type;
    assign funct3           = main_funct3;
    assign rd               = main_rd;
    assign rs1              = main_rs1;
    assign rs2              = main_rs2;
    assign imm              = main_imm;
    assign pc_out           = main_pc;

endmodule

// File: tb/tb_control_decode_stage.sv
// Directed scoreboard bench for control_decode_stage (XLEN=32).
module tb_control_decode_stage;
    import cpu_control_package::*;

    localparam int unsigned XLEN = 32;
    localparam logic [2:0] TR = 3'd0, TI = 3'd1, TS = 3'd2, TB = 3'd3, TU = 3'd4, TJ = 3'd5;

    typedef struct {
        logic [15:0] ctrl;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   pops   = 0;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [XLEN-1:0]   pc;
    logic              out_valid;
    logic              out_ready;
    logic              flush;
    logic              reg_write, alu_select, dmem_write, dmem_read;
    logic              branch, jump, muldiv, illegal;
    logic [1:0]        result_select, mem_size;
    logic              mem_unsigned;
    instruction_type_t instruction_type;
    logic [2:0]        funct3;
    logic [4:0]        rd, rs1, rs2;
    logic [XLEN-1:0]   imm, pc_out;
    logic [15:0]       obs_ctrl;

    always #5 clk = ~clk;

    control_decode_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
        .flush(flush), .reg_write(reg_write), .alu_select(alu_select),
        .dmem_write(dmem_write), .dmem_read(dmem_read), .branch(branch),
        .jump(jump), .muldiv(muldiv), .illegal(illegal),
        .result_select(result_select), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .instruction_type(instruction_type),
        .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .pc_out(pc_out)
    );

    assign obs_ctrl = {reg_write, alu_select, dmem_write, dmem_read, branch, jump,
                       muldiv, illegal, result_select, mem_size, mem_unsigned,
                       3'(instruction_type)};

    function automatic logic [15:0] ev(input logic rw, input logic alu, input logic dw,
                                       input logic dr, input logic br, input logic jp,
                                       input logic md, input logic il, input logic [1:0] rs,
                                       input logic [1:0] ms, input logic mu, input logic [2:0] it);
        return {rw, alu, dw, dr, br, jp, md, il, rs, ms, mu, it};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [15:0] c,
                        input logic [4:0] d, input logic [31:0] im);
        int w;
        w        = 0;
        instr    = i;
        pc       = p;
        in_valid = 1'b1;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        chk("send_ready", 64'(in_ready), 64'd1);
        sb.push_back('{c, d, im, p});
        step();
        in_valid = 1'b0;
    endtask

    // Every downstream transfer pops the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            checks++;
            assert (sb.size() != 0) passed++;
            else $error("FAIL unexpected_output: observed pc %0h expected no output", pc_out);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_ctrl", 64'(obs_ctrl), 64'(e.ctrl));
                chk("out_rd", 64'(rd), 64'(e.rd));
                chk("out_imm", 64'(imm), 64'(e.imm));
                chk("out_pc", 64'(pc_out), 64'(e.pc));
                pops++;
            end
        end
    end

    initial begin
        int p0;
        rst = 1'b1; in_valid = 1'b0; instr = '0; pc = '0; out_ready = 1'b0; flush = 1'b0;
        step(3);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_ctrl", 64'(obs_ctrl), 64'd0);
        chk("rst_imm", 64'(imm), 64'd0);
        chk("rst_pc_out", 64'(pc_out), 64'd0);
        rst = 1'b0;
        step();

        // addi x1,x0,10 with one-cycle latency
        out_ready = 1'b1;
        send(32'h00A00093, 32'h100, ev(1,1,0,0,0,0,0,0,2'd0,2'd0,0,TI), 5'd1, 32'd10);
        chk("addi_out_valid", 64'(out_valid), 64'd1);
        chk("addi_reg_write", 64'(reg_write), 64'd1);
        chk("addi_alu_select", 64'(alu_select), 64'd1);
        chk("addi_rd", 64'(rd), 64'd1);
        chk("addi_imm", 64'(imm), 64'd10);
        step(2);

        // Stall: lw goes to main, sw to skid, then drain in order
        out_ready = 1'b0;
        p0 = pops;
        send(32'h0000A103, 32'h200, ev(1,1,0,1,0,0,0,0,2'd1,2'd2,0,TI), 5'd2, 32'd0);
        chk("stall_in_ready_one", 64'(in_ready), 64'd1);
        send(32'h0020A023, 32'h204, ev(0,1,1,0,0,0,0,0,2'd0,2'd2,0,TS), 5'd0, 32'd0);
        chk("stall_in_ready_zero", 64'(in_ready), 64'd0);
        step(2);
        chk("stall_hold_dmem_read", 64'(dmem_read), 64'd1);
        chk("stall_hold_pc", 64'(pc_out), 64'h200);
        out_ready = 1'b1;
        step();
        chk("drain_in_ready", 64'(in_ready), 64'd1);
        step(2);
        chk("drain_count", 64'(pops - p0), 64'd2);

        // Back-to-back burst of 8 addi
        p0 = pops;
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            instr = ((k + 1) << 20) | ((k + 1) << 7) | 32'h13;
            pc    = 32'h300 + 4 * k;
            sb.push_back('{ev(1,1,0,0,0,0,0,0,2'd0,2'd0,0,TI), 5'(k + 1), 32'(k + 1), 32'h300 + 4 * k});
            step();
            chk("burst_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        step(2);
        chk("burst_count", 64'(pops - p0), 64'd8);

        // Assorted formats and immediates
        send(32'hFFC0C183, 32'h400, ev(1,1,0,1,0,0,0,0,2'd1,2'd0,1,TI), 5'd3,  32'hFFFFFFFC);
        send(32'hFE208FA3, 32'h404, ev(0,1,1,0,0,0,0,0,2'd0,2'd0,0,TS), 5'd31, 32'hFFFFFFFF);
        send(32'hFE209CE3, 32'h408, ev(0,0,0,0,1,0,0,0,2'd0,2'd0,0,TB), 5'd25, 32'hFFFFFFF8);
        send(32'h123452B7, 32'h40C, ev(1,0,0,0,0,0,0,0,2'd3,2'd0,0,TU), 5'd5,  32'h12345000);
        send(32'h00001217, 32'h410, ev(1,1,0,0,0,0,0,0,2'd0,2'd0,0,TU), 5'd4,  32'h00001000);
        send(32'h010000EF, 32'h414, ev(1,0,0,0,0,1,0,0,2'd2,2'd0,0,TJ), 5'd1,  32'd16);
        send(32'h008100E7, 32'h418, ev(1,1,0,0,0,1,0,0,2'd2,2'd0,0,TI), 5'd1,  32'd8);
        send(32'h402081B3, 32'h41C, ev(1,0,0,0,0,0,0,0,2'd0,2'd0,0,TR), 5'd3,  32'd0);
        send(32'h00000000, 32'h420, ev(0,0,0,0,0,0,0,1,2'd0,2'd0,0,TR), 5'd0,  32'd0);
        chk("illegal_zero_flag", 64'(illegal), 64'd1);
        chk("illegal_zero_rw", 64'(reg_write), 64'd0);
        send(32'h00002063, 32'h424, ev(0,0,0,0,0,0,0,1,2'd0,2'd0,0,TR), 5'd0,  32'd0);
        chk("illegal_branch_flag", 64'(illegal), 64'd1);
        chk("illegal_branch_bit", 64'(branch), 64'd0);
`ifdef CPU_DECODE_MEXT_EN
        send(32'h022081B3, 32'h428, ev(1,0,0,0,0,0,1,0,2'd0,2'd0,0,TR), 5'd3,  32'd0);
        chk("mul_muldiv", 64'(muldiv), 64'd1);
`else
        send(32'h022081B3, 32'h428, ev(0,0,0,0,0,0,0,1,2'd0,2'd0,0,TR), 5'd3,  32'd0);
        chk("mul_illegal", 64'(illegal), 64'd1);
`endif
        step(2);

        // Flush with both entries full and a new instruction offered
        out_ready = 1'b0;
        send(32'h00100093, 32'h500, ev(1,1,0,0,0,0,0,0,2'd0,2'd0,0,TI), 5'd1, 32'd1);
        send(32'h00200113, 32'h504, ev(1,1,0,0,0,0,0,0,2'd0,2'd0,0,TI), 5'd2, 32'd2);
        chk("flush_pre_in_ready", 64'(in_ready), 64'd0);
        instr = 32'h00300193; pc = 32'h508; in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        p0 = pops;
        out_ready = 1'b1;
        step(4);
        chk("flush_no_emit", 64'(pops - p0), 64'd0);

        // Reset during a stall, together with flush and in_valid
        out_ready = 1'b0;
        send(32'h00100093, 32'h600, ev(1,1,0,0,0,0,0,0,2'd0,2'd0,0,TI), 5'd1, 32'd1);
        send(32'h00200113, 32'h604, ev(1,1,0,0,0,0,0,0,2'd0,2'd0,0,TI), 5'd2, 32'd2);
        instr = 32'h00300193; pc = 32'h608; in_valid = 1'b1; flush = 1'b1; rst = 1'b1;
        step();
        chk("rst_stall_out_valid", 64'(out_valid), 64'd0);
        chk("rst_stall_in_ready", 64'(in_ready), 64'd1);
        chk("rst_stall_ctrl", 64'(obs_ctrl), 64'd0);
        chk("rst_stall_imm", 64'(imm), 64'd0);
        chk("rst_stall_pc_out", 64'(pc_out), 64'd0);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        p0 = pops;
        out_ready = 1'b1;
        step(3);
        chk("rst_stall_no_emit", 64'(pops - p0), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
